hash_msg_feeder: RTL and testbench

HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

---
 rtl/hash_feeder_pkg.sv | 17 +
 rtl/byte_fifo.sv | 61 ++++++
 rtl/hash_msg_feeder.sv | 140 ++++++++++++++
 tb/tb_hash_msg_feeder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_feeder_pkg.sv
// Shared FSM state encoding and default sizing for the hash message feeder.
// Defaults: 16-byte FIFO, one idle cycle between byte strobes, 1024-cycle digest timeout.
package hash_feeder_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int GAP_DEF     = 1;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with registered full/empty; head byte is readable without popping.
// Writes are dropped while full; reads are ignored while empty; push+pop together keeps occupancy.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  input  logic       rd_vld,
  output logic [7:0] rd_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_wr;
  logic          do_rd;

  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_vld && !empty;
  assign rd_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// Streams a buffered message byte-by-byte into a hash core, then captures and compares its digest.
// One M_valid pulse per byte followed by GAP idle cycles; stalls while the FIFO is empty.
module hash_msg_feeder
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        start,
  input  logic [63:0] msg_len,
  input  logic [31:0] exp_digest,
  output logic        M_valid,
  output logic [7:0]  M,
  output logic [63:0] C_in,
  input  logic        hash_ready,
  input  logic [31:0] digest,
  output logic        busy,
  output logic        done,
  output logic [31:0] digest_out,
  output logic        match,
  output logic        err
);

  localparam logic [31:0] GAP_LAST = 32'(GAP - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [63:0] byte_cnt;
  logic [31:0] gap_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] exp_q;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  assign in_ready = !fifo_full;
  assign pop      = (state == ST_FEED) && !fifo_empty;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_dat (in_byte),
    .rd_vld (pop),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      exp_q      <= '0;
      C_in       <= '0;
      M_valid    <= 1'b0;
      M          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digest_out <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
    end else begin
      M_valid <= 1'b0;
      M       <= '0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (msg_len != '0) begin
              C_in     <= msg_len;
              exp_q    <= exp_digest;
              byte_cnt <= '0;
              tmo_cnt  <= '0;
              match    <= 1'b0;
              err      <= 1'b0;
              state    <= ST_FEED;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              match <= 1'b0;
              state <= ST_DONE;
            end
          end
        end
        ST_FEED: begin
          if (!fifo_empty) begin
            M_valid  <= 1'b1;
            M        <= fifo_head;
            byte_cnt <= byte_cnt + 64'd1;
            gap_cnt  <= '0;
            // A zero gap skips the idle state and decides the next step here.
            if (GAP == 0) state <= (byte_cnt + 64'd1 == C_in) ? ST_WAIT : ST_FEED;
            else          state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= (byte_cnt == C_in) ? ST_WAIT : ST_FEED;
          else                     gap_cnt <= gap_cnt + 32'd1;
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (hash_ready) begin
            digest_out <= digest;
            match      <= (digest == exp_q);
            err        <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            match <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          match <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder: streaming, zero length, FIFO full, stall, timeout, mid-message reset.
module tb_hash_msg_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [63:0] msg_len = '0;
  logic [31:0] exp_digest = '0;
  logic        M_valid;
  logic [7:0]  M;
  logic [63:0] C_in;
  logic        hash_ready = 1'b0;
  logic [31:0] digest = '0;
  logic        busy;
  logic        done;
  logic [31:0] digest_out;
  logic        match;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] got_m[$];
  int         got_t[$];
  int         m_zero_bad = 0;
  int         done_cnt = 0;
  int         done_t = 0;
  logic       done_match = 1'b0;
  logic       done_err = 1'b0;
  logic [31:0] done_dig = '0;

  hash_msg_feeder #(.DEPTH(16), .GAP(1), .TIMEOUT(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .start      (start),
    .msg_len    (msg_len),
    .exp_digest (exp_digest),
    .M_valid    (M_valid),
    .M          (M),
    .C_in       (C_in),
    .hash_ready (hash_ready),
    .digest     (digest),
    .busy       (busy),
    .done       (done),
    .digest_out (digest_out),
    .match      (match),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers sample on the falling edge, half a cycle away from register updates.
  always @(negedge clk) begin
    if (M_valid) begin
      got_m.push_back(M);
      got_t.push_back(cyc);
    end else if (M !== 8'h00) begin
      m_zero_bad++;
    end
    if (done) begin
      done_cnt++;
      done_t     = cyc;
      done_match = match;
      done_err   = err;
      done_dig   = digest_out;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout byte=%0h in_ready stayed 0", b);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_msg(input logic [63:0] len, input logic [31:0] expd);
    start      = 1'b1;
    msg_len    = len;
    exp_digest = expd;
    step();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int max_cyc, output bit ok);
    int k = 0;
    while (got_m.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    ok = (got_m.size() >= n);
  endtask

  task automatic wait_done(input bit hr, input logic [31:0] d, input int max_cyc, output bit ok);
    int base = done_cnt;
    int k = 0;
    hash_ready = hr;
    digest     = d;
    while (done_cnt == base && k < max_cyc) begin
      step();
      k++;
    end
    hash_ready = 1'b0;
    ok = (done_cnt > base);
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({M_valid, M, busy, done, match, err} !== 13'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%0h want=0", {M_valid, M, busy, done, match, err});
    end
    checks++;
    if (C_in !== 64'd0) begin failures++; $display("FAIL reset_c_in got=%0h want=0", C_in); end
    checks++;
    if (digest_out !== 32'd0) begin failures++; $display("FAIL reset_digest got=%0h want=0", digest_out); end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
  endtask

  task automatic test_stream();
    bit ok;
    int bad;
    got_m.delete();
    got_t.delete();
    m_zero_bad = 0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    start_msg(64'd50, 32'hDEAD_BEEF);
    for (int i = 16; i < 50; i++) push_byte(8'(i));
    wait_pulses(50, 400, ok);
    checks++;
    if (!ok || got_m.size() != 50) begin failures++; $display("FAIL stream_count got=%0d want=50", got_m.size()); end
    bad = 0;
    for (int i = 0; i < got_m.size(); i++) if (got_m[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stream_order wrong_bytes=%0d want=0", bad); end
    bad = 0;
    for (int i = 1; i < got_t.size(); i++) if (got_t[i] - got_t[i-1] != 2) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stream_spacing bad_gaps=%0d want=0", bad); end
    checks++;
    if (C_in !== 64'd50) begin failures++; $display("FAIL stream_c_in got=%0d want=50", C_in); end
    wait_done(1'b1, 32'hDEAD_BEEF, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stream_done got=none want=pulse"); end
    checks++;
    if (done_match !== 1'b1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL stream_result match=%0b err=%0b want match=1 err=0", done_match, done_err);
    end
    checks++;
    if (done_dig !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stream_digest got=%0h want=deadbeef", done_dig); end
    checks++;
    if (m_zero_bad != 0) begin failures++; $display("FAIL stream_m_idle nonzero_cycles=%0d want=0", m_zero_bad); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stream_idle busy=%0b done=%0b want 0 0", busy, done); end
  endtask

  task automatic test_zero_len();
    got_m.delete();
    start      = 1'b1;
    msg_len    = 64'd0;
    exp_digest = 32'h0000_0001;
    step();
    start = 1'b0;
    // Counting the start cycle as the first, this is the second cycle.
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL zero_done done=%0b err=%0b want 1 1", done, err); end
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL zero_match got=%0b want=0", match); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy got=%0b want=1", busy); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after done=%0b busy=%0b want 0 0", done, busy); end
    repeat (3) step();
    checks++;
    if (got_m.size() != 0) begin failures++; $display("FAIL zero_no_mvalid got=%0d want=0", got_m.size()); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit seen;
    int bad;
    got_m.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_byte = 8'hA0 + 8'(i);
      step();
      if (i == 15) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
      end
    end
    in_valid = 1'b0;
    start_msg(64'd16, 32'h1234_5678);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_before_pop got=%0b want=0", in_ready); end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (M_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || in_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop mvalid=%0b in_ready=%0b want 1 1", seen, in_ready); end
    wait_pulses(16, 100, ok);
    bad = 0;
    for (int i = 0; i < got_m.size(); i++) if (got_m[i] !== 8'hA0 + 8'(i)) bad++;
    checks++;
    if (!ok || bad != 0) begin failures++; $display("FAIL full_data count=%0d wrong=%0d want 16 0", got_m.size(), bad); end
    wait_done(1'b1, 32'h1234_5678, 50, ok);
    checks++;
    if (!ok || done_match !== 1'b1) begin failures++; $display("FAIL full_match done=%0b match=%0b want 1 1", ok, done_match); end
    checks++;
    if (C_in !== 64'd16) begin failures++; $display("FAIL full_c_in_hold got=%0d want=16", C_in); end
    // A stored 17th byte would come out here instead of 5A.
    push_byte(8'h5A);
    push_byte(8'h5B);
    got_m.delete();
    start_msg(64'd1, 32'h0000_005A);
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok || got_m[0] !== 8'h5A) begin failures++; $display("FAIL full_17th_dropped got=%0h want=5a", ok ? got_m[0] : 8'hxx); end
    wait_done(1'b1, 32'h0000_005A, 50, ok);
    got_m.delete();
    start_msg(64'd1, 32'h0000_005B);
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok || got_m[0] !== 8'h5B) begin failures++; $display("FAIL leftover_byte got=%0h want=5b", ok ? got_m[0] : 8'hxx); end
    wait_done(1'b1, 32'h0000_005B, 50, ok);
    checks++;
    if (!ok || done_match !== 1'b1) begin failures++; $display("FAIL leftover_done done=%0b match=%0b want 1 1", ok, done_match); end
  endtask

  task automatic test_stall();
    bit ok;
    int c_acc;
    got_m.delete();
    got_t.delete();
    start_msg(64'd4, 32'h0BAD_F00D);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (10) step();
    checks++;
    if (got_m.size() != 2) begin failures++; $display("FAIL stall_pulses got=%0d want=2", got_m.size()); end
    start   = 1'b1;
    msg_len = 64'd99;
    step();
    start = 1'b0;
    checks++;
    if (C_in !== 64'd4) begin failures++; $display("FAIL stall_start_ignored c_in=%0d want=4", C_in); end
    in_valid = 1'b1;
    in_byte  = 8'h33;
    step();
    in_valid = 1'b0;
    c_acc = cyc;
    wait_pulses(3, 10, ok);
    checks++;
    if (!ok || got_t[2] - c_acc > 1) begin failures++; $display("FAIL stall_resume delay=%0d want<=1", ok ? got_t[2] - c_acc : -1); end
    push_byte(8'h44);
    wait_pulses(4, 20, ok);
    checks++;
    if (!ok || got_m[0] !== 8'h11 || got_m[1] !== 8'h22 || got_m[2] !== 8'h33 || got_m[3] !== 8'h44) begin
      failures++;
      $display("FAIL stall_data count=%0d want 11 22 33 44", got_m.size());
    end
    wait_done(1'b1, 32'h0BAD_F00E, 50, ok);
    checks++;
    if (!ok || done_match !== 1'b0 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_mismatch done=%0b match=%0b err=%0b want 1 0 0", ok, done_match, done_err);
    end
    checks++;
    if (done_dig !== 32'h0BAD_F00E) begin failures++; $display("FAIL stall_digest got=%0h want=0badf00e", done_dig); end
  endtask

  task automatic test_timeout();
    bit ok;
    got_m.delete();
    got_t.delete();
    push_byte(8'h66);
    start_msg(64'd1, 32'h1111_1111);
    wait_pulses(1, 20, ok);
    wait_done(1'b0, 32'h1111_1111, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_done got=none want=pulse"); end
    // WAIT begins the cycle after the single GAP cycle that follows the strobe.
    checks++;
    if (got_t.size() == 0 || done_t - (got_t[0] + 1) != 1024) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=1024", got_t.size() ? done_t - (got_t[0] + 1) : -1);
    end
    checks++;
    if (done_err !== 1'b1 || done_match !== 1'b0) begin failures++; $display("FAIL timeout_flags err=%0b match=%0b want 1 0", done_err, done_match); end
    checks++;
    if (done_dig !== 32'h0BAD_F00E) begin failures++; $display("FAIL timeout_digest_kept got=%0h want=0badf00e", done_dig); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    got_m.delete();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    start_msg(64'd50, 32'h5555_AAAA);
    wait_pulses(10, 100, ok);
    base = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({M_valid, M, busy, done, match, err} !== 13'd0) begin
      failures++;
      $display("FAIL midrst_ctrl got=%0h want=0", {M_valid, M, busy, done, match, err});
    end
    checks++;
    if (C_in !== 64'd0 || digest_out !== 32'd0) begin failures++; $display("FAIL midrst_regs c_in=%0h digest=%0h want 0 0", C_in, digest_out); end
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_release in_ready=%0b busy=%0b want 1 0", in_ready, busy); end
    repeat (5) step();
    checks++;
    if (done_cnt != base) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt - base); end
    got_m.delete();
    push_byte(8'h77);
    start_msg(64'd1, 32'hCAFE_F00D);
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok || got_m[0] !== 8'h77) begin failures++; $display("FAIL midrst_fifo_empty got=%0h want=77", ok ? got_m[0] : 8'hxx); end
    wait_done(1'b1, 32'hCAFE_F00D, 50, ok);
    checks++;
    if (!ok || done_match !== 1'b1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_next done=%0b match=%0b err=%0b want 1 1 0", ok, done_match, done_err);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_zero_len();
    test_fifo_full();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
